// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared constants and helpers for the multiplexed display
//               scanner (digit width, one-hot select, leading-zero mask).
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    localparam int DIGIT_W             = 4;
    localparam int DEFAULT_REFRESH_DIV = 50000;
    localparam int MAX_DIGITS          = 8;

    typedef logic [MAX_DIGITS-1:0]         digit_vec_t;
    typedef logic [DIGIT_W*MAX_DIGITS-1:0] nibble_vec_t;

    // One-hot digit select; callers truncate to their own digit count.
    function automatic digit_vec_t onehot(input logic [2:0] idx);
        onehot = digit_vec_t'(1) << idx;
    endfunction

    // Bit i set when digit i is a leading zero: i>0 and nibbles i..ndig-1
    // are all zero. Digit 0 is never flagged so a zero value still shows "0".
    function automatic digit_vec_t lead_zero_mask(input nibble_vec_t act,
                                                  input int          ndig);
        logic all_zero;
        lead_zero_mask = '0;
        all_zero       = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < ndig) begin
                all_zero          = all_zero & (act[DIGIT_W*i +: DIGIT_W] == '0);
                lead_zero_mask[i] = all_zero;
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/refresh_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : refresh_prescaler
// Description : Free-running slot timer counting 0..DIV-1 while enabled,
//               with a combinational wrap flag on the terminal count.
// Revision    : 1.0 - initial release
// ============================================================================
module refresh_prescaler
    import display_pkg::*;
#(
    parameter  int DIV   = DEFAULT_REFRESH_DIV,
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    output logic [CNT_W-1:0] o_count,
    output logic             o_wrap
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_count;

    // Wrap is high during the last cycle of a slot, only while counting.
    assign o_wrap  = i_enable && (r_count == c_last);
    assign o_count = r_count;

    // Count while enabled, hold otherwise, return to zero after the last cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= o_wrap ? '0 : r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : display_scanner
// Description : Multiplexed hex display scanner. Cycles through NUM_DIGITS
//               nibbles, drives the current nibble and a one-hot anode with a
//               dead band per slot, double-buffers new values to frame
//               boundaries and optionally blanks leading zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scanner
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_enable,
    input  logic                          i_load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] i_value,
    input  logic                          i_blank_zeros,
    output logic [DIGIT_W-1:0]            o_digit,
    output logic [NUM_DIGITS-1:0]         o_anode,
    output logic                          o_frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int VAL_W = DIGIT_W * NUM_DIGITS;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] c_dead     = CNT_W'(DEAD_CYCLES);

    logic [CNT_W-1:0]      w_pre;
    logic [CNT_W-1:0]      w_pre_nxt;
    logic                  w_wrap;
    logic                  w_frame_end;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [VAL_W-1:0]      r_active;
    logic [VAL_W-1:0]      r_pending;
    logic                  r_pend_valid;
    logic [VAL_W-1:0]      w_active_nxt;
    logic [VAL_W-1:0]      w_pending_nxt;
    logic                  w_pend_valid_nxt;
    nibble_vec_t           w_active_pad;
    logic [NUM_DIGITS-1:0] w_blank_mask;
    logic [NUM_DIGITS-1:0] w_anode_nxt;
    logic [2:0]            w_idx_ext;

    refresh_prescaler #(
        .DIV      (REFRESH_DIV)
    ) u_prescaler (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_enable (i_enable),
        .o_count  (w_pre),
        .o_wrap   (w_wrap)
    );

    // Next slot position; only meaningful for the anode when enabled.
    always_comb begin
        w_pre_nxt   = w_wrap ? '0 : w_pre + 1'b1;
        w_frame_end = w_wrap && (r_idx == c_last_idx);
        w_idx_nxt   = r_idx;
        if (w_wrap) begin
            w_idx_nxt = (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;
        end
    end

    // Double buffer: a load at the boundary bypasses pending so the newest
    // value wins; otherwise pending is promoted only at a frame boundary.
    always_comb begin
        w_active_nxt     = r_active;
        w_pending_nxt    = r_pending;
        w_pend_valid_nxt = r_pend_valid;
        if (i_load) begin
            w_pending_nxt = i_value;
            if (w_frame_end) begin
                w_active_nxt     = i_value;
                w_pend_valid_nxt = 1'b0;
            end else begin
                w_pend_valid_nxt = 1'b1;
            end
        end else if (w_frame_end && r_pend_valid) begin
            w_active_nxt     = r_pending;
            w_pend_valid_nxt = 1'b0;
        end
    end

    // Anode for the next slot, honouring enable, dead band and blanking.
    always_comb begin
        w_active_pad                = '0;
        w_active_pad[VAL_W-1:0]     = w_active_nxt;
        w_idx_ext                   = 3'(w_idx_nxt);
        w_blank_mask                = i_blank_zeros
                                    ? NUM_DIGITS'(lead_zero_mask(w_active_pad, NUM_DIGITS))
                                    : '0;
        w_anode_nxt                 = '0;
        if (i_enable && (w_pre_nxt >= c_dead) && !w_blank_mask[w_idx_nxt]) begin
            w_anode_nxt = NUM_DIGITS'(onehot(w_idx_ext));
        end
    end

    // Slot index and buffer state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx        <= '0;
            r_active     <= '0;
            r_pending    <= '0;
            r_pend_valid <= 1'b0;
        end else begin
            r_idx        <= w_idx_nxt;
            r_active     <= w_active_nxt;
            r_pending    <= w_pending_nxt;
            r_pend_valid <= w_pend_valid_nxt;
        end
    end

    // Registered outputs built from next-state values so they move with idx.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_digit      <= '0;
            o_anode      <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_digit      <= w_active_nxt[DIGIT_W*w_idx_nxt +: DIGIT_W];
            o_anode      <= w_anode_nxt;
            o_frame_done <= w_frame_end;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scanner
// Description : Self-checking bench for display_scanner (4 digits, 4-cycle
//               slots, 1 dead cycle). A behavioural model pushes expected
//               outputs into a queue; a monitor pops and compares each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scanner;

    localparam int N    = 4;
    localparam int DIV  = 4;
    localparam int DEAD = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic        blank;
    logic [3:0]  digit;
    logic [3:0]  anode;
    logic        fd;

    typedef struct packed {
        logic [3:0] d;
        logic [3:0] a;
        logic       fd;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    int          m_pre;
    int          m_idx;
    logic [15:0] m_act;
    logic [15:0] m_pend;
    logic        m_pv;

    logic [3:0] last_d;
    logic [3:0] last_a;
    logic       last_fd;

    display_scanner #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (DIV),
        .DEAD_CYCLES  (DEAD)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_enable      (enable),
        .i_load        (load),
        .i_value       (value),
        .i_blank_zeros (blank),
        .o_digit       (digit),
        .o_anode       (anode),
        .o_frame_done  (fd)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: compare DUT outputs against the queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({digit, anode, fd} !== {e.d, e.a, e.fd}) begin
                errors++;
                $display("FAIL scoreboard t=%0t got digit=%h anode=%b fd=%b expected digit=%h anode=%b fd=%b",
                         $time, digit, anode, fd, e.d, e.a, e.fd);
            end
        end
    end

    task automatic model_reset();
        m_pre  = 0;
        m_idx  = 0;
        m_act  = '0;
        m_pend = '0;
        m_pv   = 1'b0;
    endtask

    // Drive one cycle of stimulus and queue the outputs the spec requires.
    task automatic step(input logic en, input logic ld, input logic [15:0] val, input logic bz);
        exp_t e;
        logic bnd;
        logic blanked;
        @(negedge clk);
        enable = en;
        load   = ld;
        value  = val;
        blank  = bz;
        bnd = en && (m_pre == DIV - 1) && (m_idx == N - 1);
        if (en) begin
            if (m_pre == DIV - 1) begin
                m_pre = 0;
                m_idx = (m_idx + 1) % N;
            end else begin
                m_pre = m_pre + 1;
            end
        end
        if (ld) begin
            if (bnd) begin
                m_act = val;
                m_pv  = 1'b0;
            end else begin
                m_pend = val;
                m_pv   = 1'b1;
            end
        end else if (bnd && m_pv) begin
            m_act = m_pend;
            m_pv  = 1'b0;
        end
        blanked = bz && (m_idx > 0) && ((m_act >> (4 * m_idx)) == 16'h0);
        e.d  = m_act[4*m_idx +: 4];
        e.a  = (en && (m_pre >= DEAD) && !blanked) ? 4'(1 << m_idx) : 4'h0;
        e.fd = bnd;
        q.push_back(e);
        @(posedge clk);
        #2;
        load    = 1'b0;
        last_d  = digit;
        last_a  = anode;
        last_fd = fd;
    endtask

    // Step until the next step lands on the frame boundary (bounded).
    task automatic run_to_boundary(input logic bz);
        int n;
        n = 0;
        while (!((m_pre == DIV - 1) && (m_idx == N - 1)) && n < 64) begin
            step(1'b1, 1'b0, value, bz);
            n++;
        end
        checks++;
        if (n >= 64) begin
            errors++;
            $display("FAIL boundary_timeout got steps=%0d required <64", n);
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        enable = 1'b1;
        load   = 1'b0;
        value  = '0;
        blank  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({digit, anode, fd} !== 9'h0) begin
            errors++;
            $display("FAIL reset_outputs got digit=%h anode=%b fd=%b required all 0", digit, anode, fd);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic test_scan();
        int fd_cnt;
        fd_cnt = 0;
        step(1'b1, 1'b0, 16'h0, 1'b0);
        checks++;
        if (last_a !== 4'b0001) begin
            errors++;
            $display("FAIL first_anode got %b required 0001", last_a);
        end
        for (int i = 0; i < 31; i++) begin
            step(1'b1, 1'b0, 16'h0, 1'b0);
            if (last_fd) fd_cnt++;
        end
        checks++;
        if (fd_cnt != 2) begin
            errors++;
            $display("FAIL frame_pulses got %0d required 2", fd_cnt);
        end
    endtask

    task automatic test_load_mid();
        logic        early;
        logic [15:0] shown;
        int          n;
        repeat (6) step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b1, 16'h1A2F, 1'b0);
        early = 1'b0;
        n     = 0;
        while (!last_fd && n < 32) begin
            step(1'b1, 1'b0, 16'h1A2F, 1'b0);
            if (!last_fd && last_d != 4'h0) early = 1'b1;
            n++;
        end
        checks++;
        if (early || !last_fd) begin
            errors++;
            $display("FAIL load_deferred got early=%b fd_seen=%b required early=0 fd_seen=1", early, last_fd);
        end
        shown = '0;
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 1'b0, 16'h0, 1'b0);
            for (int k = 0; k < N; k++) if (last_a == 4'(1 << k)) shown[4*k +: 4] = last_d;
        end
        checks++;
        if (shown !== 16'h1A2F) begin
            errors++;
            $display("FAIL frame_digits got %h required 1a2f", shown);
        end
    endtask

    task automatic test_last_wins();
        logic        seen1;
        logic [15:0] shown;
        repeat (2) step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b1, 16'h0001, 1'b0);
        repeat (2) step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b1, 16'h0003, 1'b0);
        run_to_boundary(1'b0);
        seen1 = 1'b0;
        shown = '0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 16'h0, 1'b0);
            if (last_a != 0 && last_d == 4'h1) seen1 = 1'b1;
            for (int k = 0; k < N; k++) if (last_a == 4'(1 << k)) shown[4*k +: 4] = last_d;
        end
        checks++;
        if (seen1 || shown !== 16'h0003) begin
            errors++;
            $display("FAIL last_wins got shown=%h seen1=%b required shown=0003 seen1=0", shown, seen1);
        end
        run_to_boundary(1'b0);
        step(1'b1, 1'b1, 16'h00B7, 1'b0);
        checks++;
        if (last_fd !== 1'b1 || last_d !== 4'h7) begin
            errors++;
            $display("FAIL boundary_load got fd=%b digit=%h required fd=1 digit=7", last_fd, last_d);
        end
    endtask

    task automatic test_blank();
        logic [3:0] lit;
        logic [3:0] d0;
        run_to_boundary(1'b1);
        step(1'b1, 1'b1, 16'h0040, 1'b1);
        lit = '0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 16'h0, 1'b1);
            lit = lit | last_a;
        end
        checks++;
        if (lit !== 4'b0011) begin
            errors++;
            $display("FAIL blank_0040 got lit=%b required 0011", lit);
        end
        run_to_boundary(1'b1);
        step(1'b1, 1'b1, 16'h0000, 1'b1);
        lit = '0;
        d0  = 4'hF;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 16'h0, 1'b1);
            lit = lit | last_a;
            if (last_a == 4'b0001) d0 = last_d;
        end
        checks++;
        if (lit !== 4'b0001 || d0 !== 4'h0) begin
            errors++;
            $display("FAIL blank_zero got lit=%b digit=%h required lit=0001 digit=0", lit, d0);
        end
    endtask

    task automatic test_enable();
        logic bad;
        int   n;
        n = 0;
        while (!(m_idx == 2 && m_pre == 1) && n < 64) begin
            step(1'b1, 1'b0, 16'h0, 1'b0);
            n++;
        end
        bad = (n >= 64);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 16'h0, 1'b0);
            if (last_a != 0 || last_fd) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL disabled_outputs got anode=%b fd=%b required 0 0", last_a, last_fd);
        end
        step(1'b1, 1'b0, 16'h0, 1'b0);
        checks++;
        if (last_a !== 4'b0100) begin
            errors++;
            $display("FAIL resume_1 got anode=%b required 0100", last_a);
        end
        step(1'b1, 1'b0, 16'h0, 1'b0);
        checks++;
        if (last_a !== 4'b0100) begin
            errors++;
            $display("FAIL resume_2 got anode=%b required 0100", last_a);
        end
        step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        checks++;
        if (last_a !== 4'b1000) begin
            errors++;
            $display("FAIL resume_slot3 got anode=%b required 1000", last_a);
        end
    endtask

    task automatic test_async_reset();
        logic saw5;
        run_to_boundary(1'b0);
        step(1'b1, 1'b1, 16'h8888, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b1, 16'h5555, 1'b0);
        checks++;
        if (last_d !== 4'h8 || last_a !== 4'b0001) begin
            errors++;
            $display("FAIL pre_reset got digit=%h anode=%b required 8 0001", last_d, last_a);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({digit, anode, fd} !== 9'h0) begin
            errors++;
            $display("FAIL async_reset got digit=%h anode=%b fd=%b required all 0", digit, anode, fd);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        model_reset();
        saw5 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 16'h0, 1'b0);
            if (last_d == 4'h5) saw5 = 1'b1;
        end
        checks++;
        if (saw5) begin
            errors++;
            $display("FAIL pending_discard got digit 5 shown required never");
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load_mid();
        test_last_wins();
        test_blank();
        test_enable();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound in case anything stalls.
    initial begin
        #200000;
        $display("FAIL timeout got no completion required finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/display_scanner.md
Name: display_scanner

Overview:
Multiplexed-display scanner that sits directly upstream of the 4-bit-to-7-segment decoder. It holds NUM_DIGITS hex nibbles and cycles through them at a divided refresh rate. It presents the current nibble on Digit, which drives the decoder input, and the matching one-hot digit select on Anode. New values are double-buffered and applied only at frame boundaries, so a frame never shows digits from two different values.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
REFRESH_DIV, 50000, clock cycles per digit slot (>=2)
DEAD_CYCLES, 2, cycles at the start of each slot with all anodes off (anti-ghosting); must be < REFRESH_DIV

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Enable  in  1  scan enable; low = freeze counters and turn all anodes off
Load  in  1  one-cycle strobe that captures Value into the pending buffer
Value  in  4*NUM_DIGITS  nibble i = Value[4i+3:4i]; digit 0 is least significant
BlankZeros  in  1  1 = blank leading zero digits
Digit  out  4  nibble for the current slot, feeds the decoder input
Anode  out  NUM_DIGITS  one-hot active-high digit select
FrameDone  out  1  one-cycle pulse when the last slot ends

Behaviour:
- Reset (async, active-high) clears pending, active, PendValid, idx, pre, Digit, Anode and FrameDone to 0. Outputs hold 0 while Reset is high.
- State:
  - pre: 0..REFRESH_DIV-1, slot prescaler
  - idx: 0..NUM_DIGITS-1, current slot
  - active and pending: 4*NUM_DIGITS buffers
  - PendValid: pending-update flag
- Counting, when Enable=1:
  - pre increments each cycle and wraps at REFRESH_DIV-1 to 0.
  - On that wrap, idx increments and wraps NUM_DIGITS-1 to 0.
- Frame boundary is the cycle where pre==REFRESH_DIV-1 and idx==NUM_DIGITS-1 with Enable=1. On the following edge:
  - FrameDone=1 for exactly one cycle.
  - If PendValid, active <= pending and PendValid <= 0.
- Load:
  - pending <= Value and PendValid <= 1 on the edge where Load=1.
  - Load coincident with a frame boundary: active <= Value directly, PendValid ends 0 (newest data wins).
  - Repeated Loads before a boundary: last one wins.
  - Load is accepted regardless of Enable.
- Enable=0:
  - pre and idx hold, and Anode=0 from the next edge.
  - Digit keeps tracking active[idx].
  - FrameDone=0.
  - On re-enable, counting resumes from the held pre/idx.
- Outputs are registered and computed from next-state values, so Anode and Digit change on the same edge as idx:
  - Digit = active nibble at next idx.
  - Anode = onehot(next idx) when Enable && next pre >= DEAD_CYCLES && !blank(next idx); otherwise 0.
- Leading-zero blanking:
  - Digit i is blanked iff BlankZeros=1, i>0, and active nibbles i..NUM_DIGITS-1 are all 0.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
  - Blanking uses active, not pending.
- Decode is not done here. The downstream decoder maps Digit to segments combinationally at top level.

Decomposition:
- Package display_pkg holds:
  - constants DIGIT_W=4 and DEFAULT_REFRESH_DIV
  - function onehot(idx) returning NUM_DIGITS bits
  - function lead_zero_mask(active) returning the blank vector
- Sub-module refresh_prescaler (parameter DIV):
  - Inputs Clock, Reset, Enable.
  - Outputs pre count and a wrap pulse.
  - Instantiated once for the slot timer.
- Digit index, buffers and output registers stay in display_scanner.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYCLES=1 unless noted):
1. Reset released, Enable=1, no Load:
   - Anode sequence is 0, then per slot 0,1,1,1 on the active bit, cycling 0001→0010→0100→1000.
   - Digit=0 throughout.
   - FrameDone pulses every 16 cycles.
2. Load Value=16'h1A2F mid-frame:
   - Digit stays 0 until the next FrameDone.
   - Next frame shows Digit F,2,A,1 on Anode 0001,0010,0100,1000.
3. Load 16'h0001 then 16'h0003 within one frame:
   - Only 3 appears next frame; 1 is never displayed.
   - Load exactly on the boundary cycle: Value is shown in the immediately following frame.
4. BlankZeros=1, Value=16'h0040:
   - Anode asserts for slots 0 and 1 only; slots 2 and 3 stay 0.
   - Value=16'h0000: only slot 0 lit, Digit=0.
5. Enable dropped for 10 cycles mid-slot 2:
   - Anode=0, pre and idx frozen, FrameDone=0.
   - On re-enable, slot 2 completes its remaining cycles before slot 3.
6. Reset asserted asynchronously mid-frame:
   - Anode, Digit and FrameDone go to 0 without waiting for a clock edge.
   - The pending update is discarded.
   - After release, scanning restarts at idx 0 showing 0.
